// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, widths, FSM encoding and byte helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Contents: NR, AES_BLK, KEYS_W, fsm_e, byte_rev(), xtime(), sbox().
package aes_pkg;

  localparam int NR      = 10;
  localparam int AES_BLK = 128;
  localparam int KEYS_W  = 1408;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // FIPS byte n lives at [127-8n -: 8]; the internal state keeps it at [8n +: 8].
  function automatic logic [127:0] byte_rev(input logic [127:0] d);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = d[127-8*i -: 8];
    end
    return r;
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

endpackage

// File: rtl/ShiftRows.sv
// AES ShiftRows on the internal layout: byte (col c, row r) at [32c+8r +: 8].
// Latency: 0 cycles (wiring only).
// Backpressure: none.
// Ports: data_i[127:0] state in; data_o[127:0] row r rotated left by r columns.
module ShiftRows
  import aes_pkg::*;
(
  input  logic [AES_BLK-1:0] data_i,
  output logic [AES_BLK-1:0] data_o
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign data_o[32*c+8*r +: 8] = data_i[32*((c+r)%4)+8*r +: 8];
    end
  end

endmodule

// File: rtl/keyexpansion.sv
// Combinational AES-128 key schedule: one cipher key in, all 11 round keys out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows key_i.
// Ports: key_i[127:0] cipher key (FIPS order); keys_o[1407:0] round key i at [1407-128i -: 128].
module keyexpansion
  import aes_pkg::*;
(
  input  logic [AES_BLK-1:0] key_i,
  output logic [KEYS_W-1:0]  keys_o
);

  function automatic logic [KEYS_W-1:0] expand(input logic [AES_BLK-1:0] k);
    logic [31:0]       w [44];
    logic [31:0]       t;
    logic [7:0]        rc;
    logic [KEYS_W-1:0] r;
    rc = 8'h01;
    r  = '0;
    for (int i = 0; i < 4; i++) begin
      w[i] = k[127-32*i -: 32];
    end
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        // RotWord then SubWord, then fold in the round constant.
        t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 44; j++) begin
      r[KEYS_W-1-32*j -: 32] = w[j];
    end
    return r;
  endfunction

  assign keys_o = expand(key_i);

endmodule

// File: rtl/mix_columns.sv
// AES MixColumns on the internal layout, four identical column slices.
// Latency: 0 cycles (combinational).
// Backpressure: none.
// Ports: data_i[127:0] state in; data_o[127:0] mixed state (column c at [32c +: 32], row 0 low).
module mix_columns
  import aes_pkg::*;
(
  input  logic [AES_BLK-1:0] data_i,
  output logic [AES_BLK-1:0] data_o
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;

    assign a0 = data_i[32*c +  0 +: 8];
    assign a1 = data_i[32*c +  8 +: 8];
    assign a2 = data_i[32*c + 16 +: 8];
    assign a3 = data_i[32*c + 24 +: 8];

    assign x0 = xtime(a0);
    assign x1 = xtime(a1);
    assign x2 = xtime(a2);
    assign x3 = xtime(a3);

    // 3a = xtime(a) ^ a, so each row is a pure XOR of doubled and plain bytes.
    assign data_o[32*c +  0 +: 8] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
    assign data_o[32*c +  8 +: 8] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
    assign data_o[32*c + 16 +: 8] = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
    assign data_o[32*c + 24 +: 8] = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
  end

endmodule

// File: rtl/subBytes.sv
// Byte-wise S-box substitution of a 128-bit state (byte order irrelevant).
// Latency: 0 cycles (combinational).
// Backpressure: none.
// Ports: data_i[127:0] state in; data_o[127:0] substituted state.
module subBytes
  import aes_pkg::*;
(
  input  logic [AES_BLK-1:0] data_i,
  output logic [AES_BLK-1:0] data_o
);

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign data_o[8*i +: 8] = sbox(data_i[8*i +: 8]);
  end

endmodule

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryptor, one round per clock, result held until taken downstream.
// Latency: accept edge T -> out_valid after edge T+10; one block per 12 cycles at best.
// Backpressure: out_ready low holds DONE (ct_out/out_valid stable); in_ready only high in IDLE.
// Ports: clk, rst_n (sync, active low); in_valid/in_ready/pt_in/key_in plaintext+key offer;
//        out_valid/out_ready/ct_out ciphertext; busy high while a block is in ROUND or DONE.
module aes128_encrypt_core #(
  parameter int NR = 10  // AES-128 only
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct_out,
  output logic         busy
);
  import aes_pkg::*;

  fsm_e               fsm_q, fsm_d;
  logic [3:0]         rnd_q, rnd_d;
  logic [AES_BLK-1:0] state_q, state_d;
  logic [AES_BLK-1:0] key_q, key_d;
  logic [AES_BLK-1:0] ct_q, ct_d;
  logic               out_valid_q, out_valid_d;

  logic [KEYS_W-1:0]  keys;
  logic [AES_BLK-1:0] sb_out, sr_out, mc_out;
  logic [AES_BLK-1:0] rk_fips, rk;

  keyexpansion u_keyexpansion (
    .key_i  (key_q),
    .keys_o (keys)
  );

  subBytes u_subbytes (
    .data_i (state_q),
    .data_o (sb_out)
  );

  ShiftRows u_shiftrows (
    .data_i (sb_out),
    .data_o (sr_out)
  );

  mix_columns u_mix_columns (
    .data_i (sr_out),
    .data_o (mc_out)
  );

  // Round key for the current round; rk[0] is never used here because the
  // initial whitening is taken straight from key_in on the accept edge.
  always_comb begin
    rk_fips = keys[KEYS_W-1 -: AES_BLK];
    for (int i = 1; i <= NR; i++) begin
      if (rnd_q == 4'(i)) begin
        rk_fips = keys[KEYS_W-1-AES_BLK*i -: AES_BLK];
      end
    end
  end

  assign rk = byte_rev(rk_fips);

  always_comb begin
    fsm_d       = fsm_q;
    rnd_d       = rnd_q;
    state_d     = state_q;
    key_d       = key_q;
    ct_d        = ct_q;
    out_valid_d = out_valid_q;

    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          key_d   = key_in;
          state_d = byte_rev(pt_in) ^ byte_rev(key_in);
          rnd_d   = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (rnd_q == 4'(NR)) begin
          // Final round skips MixColumns.
          state_d     = sr_out ^ rk;
          ct_d        = byte_rev(sr_out ^ rk);
          out_valid_d = 1'b1;
          fsm_d       = DONE;
        end else begin
          state_d = mc_out ^ rk;
          rnd_d   = rnd_q + 4'd1;
        end
      end
      DONE: begin
        // ct_q is left alone so the last ciphertext stays visible.
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = IDLE;
        end
      end
      default: begin
        fsm_d       = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      rnd_q       <= 4'd0;
      state_q     <= '0;
      key_q       <= '0;
      ct_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      rnd_q       <= rnd_d;
      state_q     <= state_d;
      key_q       <= key_d;
      ct_q        <= ct_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign busy      = (fsm_q == ROUND) || (fsm_q == DONE);
  assign out_valid = out_valid_q;
  assign ct_out    = ct_q;

endmodule

// File: tb/tb_aes128_encrypt_core.sv
module tb_aes128_encrypt_core;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt_in;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct_out;
  logic         busy;

  int           checks = 0;
  int           errors = 0;
  logic [127:0] expq[$];

  always #5 clk = ~clk;

  aes128_encrypt_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt_in     (pt_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ct_out    (ct_out),
    .busy      (busy)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with in_ready high; returns at the negedge after the accept edge.
  task automatic send(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp);
    pt_in    = pt;
    key_in   = key;
    in_valid = 1'b1;
    expq.push_back(exp);
    step();
    in_valid = 1'b0;
  endtask

  // Started at the negedge after the accept edge (one edge consumed so far).
  task automatic wait_out(input bit scramble, output logic [127:0] exp_ct);
    int n;
    n = 1;
    while (!out_valid && n < 30) begin
      if (scramble) begin
        pt_in    = {$urandom, $urandom, $urandom, $urandom};
        key_in   = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'($urandom_range(0, 1));
      end
      step();
      n++;
    end
    if (scramble) in_valid = 1'b0;
    chki("latency", n, 11);
    chk1("out_valid_up", out_valid, 1'b1);
    exp_ct = (expq.size() != 0) ? expq.pop_front() : 'x;
    chk("ct", ct_out, exp_ct);
  endtask

  task automatic drain(input logic [127:0] exp_ct);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk1("hs_valid_low", out_valid, 1'b0);
    chk1("hs_in_ready", in_ready, 1'b1);
    chk("ct_hold", ct_out, exp_ct);
  endtask

  initial begin
    logic [127:0] e;
    int           acc[2];
    int           nacc;
    int           nouts;
    bit           pend;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pt_in     = '0;
    key_in    = '0;
    step();
    step();
    rst_n = 1'b1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_ct", ct_out, '0);

    // App. B vector with latency check
    send(PT_B, KEY_B, CT_B);
    chk1("acc_busy", busy, 1'b1);
    chk1("acc_in_ready", in_ready, 1'b0);
    wait_out(1'b0, e);
    drain(e);

    // App. C.1 vector
    send(PT_C, KEY_C, CT_C);
    wait_out(1'b0, e);
    drain(e);

    // Backpressure with a competing offer held on the input
    send(PT_C, KEY_C, CT_C);
    wait_out(1'b0, e);
    pt_in    = PT_B;
    key_in   = KEY_B;
    in_valid = 1'b1;
    expq.push_back(CT_B);
    for (int i = 0; i < 20; i++) begin
      step();
      chk1("bp_valid", out_valid, 1'b1);
      chk("bp_ct", ct_out, e);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk1("bp_hs_valid", out_valid, 1'b0);
    chk1("bp_hs_in_ready", in_ready, 1'b1);
    chk1("bp_not_accepted_yet", busy, 1'b0);
    step();
    in_valid = 1'b0;
    chk1("bp_accepted_after", busy, 1'b1);
    wait_out(1'b0, e);
    drain(e);

    // Inputs churn every cycle while busy
    send(PT_C, KEY_C, CT_C);
    wait_out(1'b1, e);
    drain(e);

    // Reset at rnd==5
    send(PT_C, KEY_C, CT_C);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    void'(expq.pop_back());
    chk1("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_ct", ct_out, '0);
    chk1("mrst_in_ready", in_ready, 1'b1);
    chk1("mrst_busy", busy, 1'b0);
    send(PT_B, KEY_B, CT_B);
    wait_out(1'b0, e);
    drain(e);

    // Back-to-back with out_ready tied high
    out_ready = 1'b1;
    pt_in     = PT_B;
    key_in    = KEY_B;
    in_valid  = 1'b1;
    expq.push_back(CT_B);
    nacc  = 0;
    nouts = 0;
    pend  = 1'b0;
    acc   = '{default: -1};
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        e = (expq.size() != 0) ? expq.pop_front() : 'x;
        chk("b2b_ct", ct_out, e);
        nouts++;
      end
      if (pend) begin
        pend = 1'b0;
        if (nacc == 1) begin
          pt_in  = PT_C;
          key_in = KEY_C;
          expq.push_back(CT_C);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (in_valid && in_ready) begin
        if (nacc < 2) acc[nacc] = i;
        nacc++;
        pend = 1'b1;
      end
      step();
    end
    out_ready = 1'b0;
    chki("b2b_accepts", nacc, 2);
    chki("b2b_gap", acc[1] - acc[0], 12);
    chki("b2b_outputs", nouts, 2);
    chki("sb_empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
